multicycle_core: RTL and testbench

Parametrised multicycle processor core, the successor to the single-cycle top-level instantiation. It fetches fixed-format instructions (opcode, reg1, reg2) from an external instruction memory and executes them with an internal register file and ALU. It reaches data memory through valid/request handshakes, so it tolerates wait states on both memories. A small FSM sequences fetch, execute and memory phases; a retire counter and debug read port support verification.

---
 rtl/multicycle_core_pkg.sv | 49 ++++
 rtl/multicycle_core_if.sv | 35 +++
 rtl/multicycle_core_regfile.sv | 40 ++++
 rtl/multicycle_core.sv | 160 ++++++++++++++++
 tb/tb_multicycle_core.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_core_pkg.sv
// Shared definitions for multicycle_core: opcode and FSM state enums plus
// instruction field extraction helpers.
// Instruction layout (MSB to LSB): op | reg1 | reg2.
package multicycle_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_LI  = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_BNZ = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam int unsigned OP_W = $bits(op_t);

  // Helpers take the instruction zero-extended to 32 bits and return the
  // field right-aligned; callers size-cast to the field width.
  function automatic logic [31:0] field_mask(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic [31:0] field_reg2(input logic [31:0] instr,
                                             input int unsigned reg_bits);
    return instr & field_mask(reg_bits);
  endfunction

  function automatic logic [31:0] field_reg1(input logic [31:0] instr,
                                             input int unsigned reg_bits);
    return (instr >> reg_bits) & field_mask(reg_bits);
  endfunction

  function automatic logic [31:0] field_op(input logic [31:0] instr,
                                           input int unsigned reg_bits,
                                           input int unsigned op_bits);
    return (instr >> (2 * reg_bits)) & field_mask(op_bits);
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Memory-side bus of multicycle_core.
//   imem_*: instruction fetch (req/addr out, rdata/valid in)
//   dmem_*: data access (req/we/addr/wdata out, rdata/valid in)
// master = core side, slave = memory side.
interface multicycle_core_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PC_BITS = 9,
  parameter int unsigned INSTR_W = 9
);
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  logic               dmem_req;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_valid;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_valid
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_valid
  );
endinterface

// File: rtl/multicycle_core_regfile.sv
// Register file for multicycle_core.
//   clk_i, rst_i        : clock, asynchronous active-high clear of all entries
//   ra_addr_i/ra_data_o : async read port A
//   rb_addr_i/rb_data_o : async read port B
//   dbg_addr_i/dbg_data_o: async debug read (no write bypass)
//   we_i/waddr_i/wdata_i: synchronous write port
module core_regfile #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REG_BITS = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [REG_BITS-1:0] ra_addr_i,
  output logic [DATA_W-1:0]   ra_data_o,
  input  logic [REG_BITS-1:0] rb_addr_i,
  output logic [DATA_W-1:0]   rb_data_o,
  input  logic [REG_BITS-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]   dbg_data_o,
  input  logic                we_i,
  input  logic [REG_BITS-1:0] waddr_i,
  input  logic [DATA_W-1:0]   wdata_i
);
  localparam int unsigned NREG = 1 << REG_BITS;

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/multicycle_core.sv
// Multicycle processor core: fetch -> exec (-> mem) sequencing over
// handshaked instruction and data memories.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : imem_*/dmem_* handshakes (master modport)
//   halted       : core stopped on HALT (BNZ with reg2 field 0)
//   retired      : saturating count of completed instructions
//   dbg_sel/data : asynchronous register read for debug
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PC_BITS  = 9,
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned OP_BITS  = 3,
  parameter int unsigned INSTR_W  = OP_BITS + 2 * REG_BITS,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_core_if.master   bus,
  output logic                halted,
  output logic [CNT_W-1:0]    retired,
  input  logic [REG_BITS-1:0] dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
);

  state_t               state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d, pc_inc, pc_br;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]     ret_q, ret_d, ret_inc;

  logic [31:0]          ir_ext;
  op_t                  op;
  logic [REG_BITS-1:0]  r1, r2;
  logic [DATA_W-1:0]    a, b, alu;

  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;

  assign ir_ext = 32'(ir_q);
  assign op     = op_t'(OP_W'(field_op(ir_ext, REG_BITS, OP_BITS)));
  assign r1     = REG_BITS'(field_reg1(ir_ext, REG_BITS));
  assign r2     = REG_BITS'(field_reg2(ir_ext, REG_BITS));

  core_regfile #(
    .DATA_W   (DATA_W),
    .REG_BITS (REG_BITS)
  ) u_regfile (
    .clk_i      (clock),
    .rst_i      (reset),
    .ra_addr_i  (r1),
    .ra_data_o  (a),
    .rb_addr_i  (r2),
    .rb_data_o  (b),
    .dbg_addr_i (dbg_sel),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .waddr_i    (r1),
    .wdata_i    (rf_wdata)
  );

  always_comb begin
    alu = '0;
    unique case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_XOR:  alu = a ^ b;
      OP_LI:   alu = DATA_W'(r2);
      default: alu = '0;
    endcase
  end

  assign pc_inc  = pc_q + PC_BITS'(1);
  // Branch offset is the reg2 field taken as a signed value.
  assign pc_br   = pc_q + {{(PC_BITS-REG_BITS){r2[REG_BITS-1]}}, r2};
  assign ret_inc = (ret_q == '1) ? ret_q : ret_q + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ret_d          = ret_q;
    rf_we          = 1'b0;
    rf_wdata       = alu;
    halted         = 1'b0;
    bus.imem_req   = 1'b0;
    bus.imem_addr  = pc_q;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = b;
    bus.dmem_wdata = a;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_BNZ: begin
            ret_d = ret_inc;
            if (r2 == '0) begin
              state_d = S_HALT;
            end else begin
              pc_d    = (a != '0) ? pc_br : pc_inc;
              state_d = S_FETCH;
            end
          end
          default: begin
            rf_we   = 1'b1;
            pc_d    = pc_inc;
            ret_d   = ret_inc;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op == OP_ST);
        if (bus.dmem_valid) begin
          rf_we    = (op == OP_LD);
          rf_wdata = bus.dmem_rdata;
          pc_d     = pc_inc;
          ret_d    = ret_inc;
          state_d  = S_FETCH;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

  assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_core.sv
module tb_multicycle_core;
  import multicycle_core_pkg::*;

  localparam int DW = 8;
  localparam int PB = 9;
  localparam int RB = 3;
  localparam int OB = 3;
  localparam int IW = 9;
  localparam int CW = 16;
  localparam int NI = 512;
  localparam int ND = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [RB-1:0] dbg_sel = '0;
  logic [DW-1:0] dbg_data;
  logic          halted;
  logic [CW-1:0] retired;

  multicycle_core_if #(.DATA_W(DW), .PC_BITS(PB), .INSTR_W(IW)) mbus();

  multicycle_core #(
    .DATA_W(DW), .PC_BITS(PB), .REG_BITS(RB), .OP_BITS(OB), .INSTR_W(IW), .CNT_W(CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (mbus),
    .halted   (halted),
    .retired  (retired),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clock = ~clock;

  // ---------------- memory models ----------------
  logic [IW-1:0] imem      [NI];
  logic [DW-1:0] dmem_dut  [ND];
  logic [DW-1:0] dmem_init [ND];
  int iwait = 0, dwait = 0;
  bit rnd_wait = 1'b0;
  int icnt = 0, dcnt = 0, iw_cur = 0, dw_cur = 0;

  assign mbus.imem_rdata = imem[mbus.imem_addr];
  assign mbus.imem_valid = mbus.imem_req && (icnt >= iw_cur);
  assign mbus.dmem_rdata = dmem_dut[mbus.dmem_addr];
  assign mbus.dmem_valid = mbus.dmem_req && (dcnt >= dw_cur);

  always @(posedge clock) begin
    if (reset) begin
      icnt   <= 0;
      dcnt   <= 0;
      iw_cur <= iwait;
      dw_cur <= dwait;
      for (int i = 0; i < ND; i++) dmem_dut[i] <= dmem_init[i];
    end else begin
      if (mbus.imem_req && mbus.imem_valid) begin
        icnt   <= 0;
        iw_cur <= rnd_wait ? int'($urandom_range(0, 3)) : iwait;
      end else if (mbus.imem_req) icnt <= icnt + 1;
      else icnt <= 0;
      if (mbus.dmem_req && mbus.dmem_valid) begin
        dcnt   <= 0;
        dw_cur <= rnd_wait ? int'($urandom_range(0, 3)) : dwait;
        if (mbus.dmem_we) dmem_dut[mbus.dmem_addr] <= mbus.dmem_wdata;
      end else if (mbus.dmem_req) dcnt <= dcnt + 1;
      else dcnt <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  int stab_bad = 0, st_hold = 0, wraps = 0, last_fetch = -1;
  logic p_ist = 1'b0, p_dst = 1'b0, p_dwe = 1'b0;
  logic [PB-1:0] p_iaddr = '0;
  logic [DW-1:0] p_daddr = '0, p_dwd = '0;

  always @(negedge clock) begin
    if (reset) begin
      p_ist <= 1'b0;
      p_dst <= 1'b0;
    end else begin
      if (p_ist && !(mbus.imem_req && mbus.imem_addr == p_iaddr)) stab_bad <= stab_bad + 1;
      if (p_dst && !(mbus.dmem_req && mbus.dmem_we == p_dwe &&
                     mbus.dmem_addr == p_daddr && mbus.dmem_wdata == p_dwd))
        stab_bad <= stab_bad + 1;
      p_ist   <= mbus.imem_req && !mbus.imem_valid;
      p_iaddr <= mbus.imem_addr;
      p_dst   <= mbus.dmem_req && !mbus.dmem_valid;
      p_dwe   <= mbus.dmem_we;
      p_daddr <= mbus.dmem_addr;
      p_dwd   <= mbus.dmem_wdata;
      if (mbus.dmem_req && mbus.dmem_we && mbus.dmem_addr == 8'd2 && mbus.dmem_wdata == 8'd7)
        st_hold <= st_hold + 1;
      if (mbus.imem_req && mbus.imem_valid) begin
        if (last_fetch == NI - 1 && mbus.imem_addr == '0) wraps <= wraps + 1;
        last_fetch <= int'(mbus.imem_addr);
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (ISA interpreter) ----------------
  int m_r [8];
  int m_dm [ND];
  int m_pc, m_ret;
  bit m_halt;

  task automatic model_run();
    int ins, op, f1, f2, a, b, nxt, steps;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    for (int i = 0; i < ND; i++) m_dm[i] = int'(dmem_init[i]);
    m_pc = 0; m_ret = 0; m_halt = 0; steps = 0;
    while (!m_halt && steps < 20000) begin
      ins = int'(imem[m_pc]);
      op  = ins / 64;
      f1  = (ins / 8) % 8;
      f2  = ins % 8;
      a   = m_r[f1];
      b   = m_r[f2];
      nxt = m_pc + 1;
      case (op)
        0: m_r[f1] = (a + b) % 256;
        1: m_r[f1] = (a - b + 256) % 256;
        2: m_r[f1] = a & b;
        3: m_r[f1] = a ^ b;
        4: m_r[f1] = f2;
        5: m_r[f1] = m_dm[b];
        6: m_dm[b] = a;
        default: begin
          if (f2 == 0) begin
            m_halt = 1;
            nxt = m_pc;
          end else if (a != 0) nxt = m_pc + ((f2 >= 4) ? f2 - 8 : f2);
        end
      endcase
      m_pc = ((nxt % NI) + NI) % NI;
      if (m_ret < 65535) m_ret++;
      steps++;
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int f1, input int f2);
    logic [2:0] o, x, y;
    o = op[2:0]; x = f1[2:0]; y = f2[2:0];
    return {o, x, y};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < NI; i++) imem[i] = enc(7, 0, 0);
    for (int i = 0; i < ND; i++) dmem_init[i] = '0;
  endtask

  task automatic read_reg(input int i, output logic [DW-1:0] v);
    dbg_sel = i[RB-1:0];
    #1;
    v = dbg_data;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, inout int cycles);
    bit done;
    done = halted;
    while (!done && cycles < budget) begin
      @(posedge clock);
      #1;
      cycles++;
      if (halted) done = 1'b1;
    end
    check("halt reached", {31'd0, done}, 32'd1);
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    @(posedge clock);  // leave S_RESET
    wait_halt(budget, cycles);
  endtask

  task automatic compare_final(input string tag);
    logic [DW-1:0] v;
    int mism;
    model_run();
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      check($sformatf("%s r%0d", tag, i), 32'(v), 32'(m_r[i]));
    end
    check({tag, " pc"}, 32'(mbus.imem_addr), 32'(m_pc));
    check({tag, " retired"}, 32'(retired), 32'(m_ret));
    check({tag, " halted"}, {31'd0, halted}, 32'(m_halt));
    mism = 0;
    for (int i = 0; i < ND; i++) if (int'(dmem_dut[i]) != m_dm[i]) mism++;
    check({tag, " dmem mismatches"}, 32'(mism), 32'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int cyc, snap, n;
    logic [DW-1:0] v;

    // 1: zero-wait basic program, plus reset state
    clear_prog();
    imem[0] = enc(4, 1, 5);
    imem[1] = enc(4, 2, 3);
    imem[2] = enc(0, 1, 2);
    imem[3] = enc(1, 2, 1);
    imem[4] = enc(7, 0, 0);
    iwait = 0; dwait = 0;
    apply_reset();
    check("rst imem_req", {31'd0, mbus.imem_req}, 32'd0);
    check("rst dmem_req", {31'd0, mbus.dmem_req}, 32'd0);
    check("rst dmem_we", {31'd0, mbus.dmem_we}, 32'd0);
    check("rst halted", {31'd0, halted}, 32'd0);
    check("rst retired", 32'(retired), 32'd0);
    check("rst pc", 32'(mbus.imem_addr), 32'd0);
    read_reg(1, v);
    check("rst r1", 32'(v), 32'd0);
    release_reset();
    #1;
    check("s_reset imem_req", {31'd0, mbus.imem_req}, 32'd0);
    snap = stab_bad;
    run_to_halt(200, cyc);
    check("s1 cycles", 32'(cyc), 32'd10);
    read_reg(1, v);
    check("s1 r1", 32'(v), 32'h08);
    read_reg(2, v);
    check("s1 r2", 32'(v), 32'hFB);
    check("s1 retired", 32'(retired), 32'd5);
    check("s1 pc", 32'(mbus.imem_addr), 32'd4);
    compare_final("s1");

    // 2: same program, 3 wait cycles per fetch
    iwait = 3;
    apply_reset();
    release_reset();
    snap = stab_bad;
    run_to_halt(400, cyc);
    check("s2 cycles", 32'(cyc), 32'd25);
    check("s2 imem stability", 32'(stab_bad - snap), 32'd0);
    compare_final("s2");

    // 3: store then load with 2 data wait cycles
    clear_prog();
    imem[0] = enc(4, 1, 7);
    imem[1] = enc(4, 2, 2);
    imem[2] = enc(6, 1, 2);
    imem[3] = enc(5, 3, 2);
    imem[4] = enc(7, 0, 0);
    iwait = 0; dwait = 2;
    apply_reset();
    release_reset();
    snap = st_hold;
    n = stab_bad;
    run_to_halt(400, cyc);
    check("s3 store hold cycles", 32'(st_hold - snap), 32'd3);
    check("s3 dmem stability", 32'(stab_bad - n), 32'd0);
    read_reg(3, v);
    check("s3 r3", 32'(v), 32'd7);
    check("s3 mem[2]", 32'(dmem_dut[2]), 32'd7);
    compare_final("s3");

    // 4: countdown loop with backward branch
    clear_prog();
    imem[0] = enc(4, 1, 3);
    imem[1] = enc(4, 2, 1);
    imem[2] = enc(1, 1, 2);
    imem[3] = enc(7, 1, 7);
    imem[4] = enc(7, 0, 0);
    iwait = 0; dwait = 0;
    apply_reset();
    release_reset();
    run_to_halt(400, cyc);
    read_reg(1, v);
    check("s4 r1", 32'(v), 32'd0);
    compare_final("s4");

    // 5: async reset in the middle of a stalled store
    clear_prog();
    imem[0] = enc(4, 1, 7);
    imem[1] = enc(4, 2, 2);
    imem[2] = enc(6, 1, 2);
    imem[3] = enc(7, 0, 0);
    iwait = 0; dwait = 50;
    apply_reset();
    release_reset();
    n = 0;
    while (!mbus.dmem_req && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("s5 reached mem", {31'd0, mbus.dmem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s5 dmem_req drop", {31'd0, mbus.dmem_req}, 32'd0);
    check("s5 imem_req", {31'd0, mbus.imem_req}, 32'd0);
    check("s5 pc", 32'(mbus.imem_addr), 32'd0);
    check("s5 retired", 32'(retired), 32'd0);
    for (int i = 1; i < 3; i++) begin
      read_reg(i, v);
      check($sformatf("s5 rst r%0d", i), 32'(v), 32'd0);
    end
    dwait = 0;
    repeat (2) @(posedge clock);
    release_reset();
    @(posedge clock);
    #1;
    check("s5 refetch req", {31'd0, mbus.imem_req}, 32'd1);
    check("s5 refetch addr", 32'(mbus.imem_addr), 32'd0);
    cyc = 0;
    wait_halt(400, cyc);
    compare_final("s5");

    // 6: pc wrap from 511 to 0
    clear_prog();
    imem[0]   = enc(7, 1, 3);  // r1==0 first pass: fall through; later jump to 3
    imem[1]   = enc(4, 7, 1);
    imem[2]   = enc(7, 7, 4);  // -4 -> 510
    imem[3]   = enc(7, 0, 0);
    imem[510] = enc(7, 7, 1);
    imem[511] = enc(4, 1, 1);
    iwait = 1; dwait = 0;
    apply_reset();
    release_reset();
    snap = wraps;
    run_to_halt(400, cyc);
    check("s6 wrap seen", 32'(wraps - snap), 32'd1);
    read_reg(1, v);
    check("s6 r1", 32'(v), 32'd1);
    check("s6 pc", 32'(mbus.imem_addr), 32'd3);
    compare_final("s6");

    // random programs with random wait states
    rnd_wait = 1'b1;
    for (int t = 0; t < 4; t++) begin
      clear_prog();
      for (int i = 0; i < ND; i++) dmem_init[i] = DW'($urandom);
      for (int k = 0; k < 24; k++) begin
        int op, f1, f2;
        op = int'($urandom_range(0, 7));
        f1 = int'($urandom_range(0, 7));
        f2 = int'($urandom_range(0, 7));
        if (op == 7) f2 = int'($urandom_range(1, 3));
        imem[k] = enc(op, f1, f2);
      end
      apply_reset();
      release_reset();
      n = stab_bad;
      run_to_halt(2000, cyc);
      check($sformatf("rnd%0d stability", t), 32'(stab_bad - n), 32'd0);
      compare_final($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
